// File: rtl/epc_reg_bridge_if.sv
// EPC bus signal bundle between the CPU (master) and the register bridge (slave).
// Vectors keep the EPC big-endian numbering: bit 0 is the MSB.
interface epc_reg_bridge_if;
   logic        epc_cs_n;
   logic        epc_ads;
   logic        epc_rnw;
   logic [0:3]  epc_be;
   logic [0:31] epc_addr;
   logic [0:31] epc_wdata;
   logic [0:31] epc_rdata;
   logic        epc_rdy;

   modport master (
      output epc_cs_n, epc_ads, epc_rnw, epc_be, epc_addr, epc_wdata,
      input  epc_rdata, epc_rdy
   );

   modport slave (
      input  epc_cs_n, epc_ads, epc_rnw, epc_be, epc_addr, epc_wdata,
      output epc_rdata, epc_rdy
   );
endinterface

// File: rtl/epc_reg_bridge.sv
// EPC slave: turns single-beat EPC transactions into one-cycle local register strobes,
// with decode-error and ack-timeout completion so the CPU never stalls.
module epc_reg_bridge #(
   parameter int unsigned AW       = 13,
   parameter int unsigned TIMEOUT  = 8,
   parameter logic [31:0] ERR_DATA = 32'hdead_beef
) (
   input  logic                   clk,
   input  logic                   rst,
   epc_reg_bridge_if.slave        epc,
   output logic [AW-1:0]          reg_addr,
   output logic [31:0]            reg_wdata,
   output logic [3:0]             reg_be,
   output logic                   reg_wr,
   output logic                   reg_rd,
   input  logic [31:0]            reg_rdata,
   input  logic                   reg_ack,
   output logic [7:0]             err_cnt
);

   typedef enum logic [2:0] {
      StIdle, StStrobe, StWait, StDerr, StDone, StTerm
   } state_e;

   state_e      state_q, state_d;
   logic        rnw_q;
   logic [31:0] rdata_q;
   logic [3:0]  cnt_q;

   logic [31:0] addr_w;
   logic        in_range;
   logic        start, capture, timeout, err_inc;

   // Value-preserving assignment flips the EPC MSB-first numbering to local [31:0].
   assign addr_w   = epc.epc_addr;
   assign in_range = (addr_w >> AW) == 32'd0;
   assign err_inc  = (start && !in_range) || timeout;

   always_comb begin
      state_d       = state_q;
      start         = 1'b0;
      capture       = 1'b0;
      timeout       = 1'b0;
      reg_wr        = 1'b0;
      reg_rd        = 1'b0;
      epc.epc_rdy   = 1'b0;
      epc.epc_rdata = '0;
      unique case (state_q)
         StIdle: begin
            if (!epc.epc_cs_n && epc.epc_ads) begin
               start   = 1'b1;
               state_d = in_range ? StStrobe : StDerr;
            end
         end
         StStrobe: begin
            reg_wr = !rnw_q;
            reg_rd = rnw_q;
            if (reg_ack) begin
               capture = 1'b1;
               state_d = StDone;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            // Abort beats ack; ack beats a simultaneous timeout.
            if (epc.epc_cs_n) begin
               state_d = StIdle;
            end else if (reg_ack) begin
               capture = 1'b1;
               state_d = StDone;
            end else if (cnt_q == 4'(TIMEOUT - 1)) begin
               timeout = 1'b1;
               state_d = StDone;
            end
         end
         StDerr: state_d = epc.epc_cs_n ? StIdle : StDone;
         StDone: begin
            epc.epc_rdy   = 1'b1;
            epc.epc_rdata = rnw_q ? rdata_q : 32'd0;
            state_d       = StTerm;
         end
         StTerm: begin
            if (epc.epc_cs_n) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         rnw_q     <= 1'b0;
         rdata_q   <= '0;
         cnt_q     <= '0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_be    <= '0;
         err_cnt   <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            reg_addr  <= addr_w[AW-1:0];
            reg_wdata <= epc.epc_wdata;
            reg_be    <= epc.epc_be;
            rnw_q     <= epc.epc_rnw;
            rdata_q   <= '0;
         end
         if (capture) rdata_q <= reg_rdata;
         if (timeout) rdata_q <= ERR_DATA;
         if (state_q == StStrobe)  cnt_q <= '0;
         else if (state_q == StWait) cnt_q <= cnt_q + 4'd1;
         if (err_inc && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_epc_reg_bridge.sv
// Directed, table-driven bench for epc_reg_bridge; cycle c counts posedges after the ads edge.
module tb_epc_reg_bridge;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   epc_reg_bridge_if bus();
   logic [12:0] reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_be;
   logic        reg_wr, reg_rd;
   logic [31:0] reg_rdata;
   logic        reg_ack;
   logic [7:0]  err_cnt;

   epc_reg_bridge #(.AW(13), .TIMEOUT(8), .ERR_DATA(32'hdead_beef)) dut (
      .clk(clk), .rst(rst), .epc(bus.slave),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
      .err_cnt(err_cnt)
   );

   typedef struct {
      logic        rnw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          ack_dly;   // ack N cycles after the strobe cycle; -1 = never
      logic [31:0] rd_in;
      int          hold;      // extra cycles cs_n stays low (with ads re-pulsed) after rdy
      int          abort_at;  // cycle at which cs_n rises early; 0 = no abort
      int          exp_strobe;
      int          exp_rdy;   // 0 = no rdy expected
      logic [31:0] exp_rdata;
      logic [7:0]  exp_err;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input int ack_dly, input logic [31:0] rd_in,
                               input int hold, input int abort_at, input int es, input int er,
                               input logic [31:0] erd, input logic [7:0] eerr);
      vec_t v;
      v.rnw = rnw; v.addr = addr; v.wdata = wdata; v.be = be; v.ack_dly = ack_dly;
      v.rd_in = rd_in; v.hold = hold; v.abort_at = abort_at; v.exp_strobe = es;
      v.exp_rdy = er; v.exp_rdata = erd; v.exp_err = eerr;
      return v;
   endfunction

   // Entered just after a posedge; returns just after a posedge with cs_n high.
   task automatic run_and_check(input string tag, input vec_t v);
      int strobe_cyc, wr_n, rd_n, rdy_cyc, rdy_n, leak_n;
      logic [31:0] rd_at_rdy;
      strobe_cyc = 0; wr_n = 0; rd_n = 0; rdy_cyc = 0; rdy_n = 0; leak_n = 0;
      rd_at_rdy = '0;
      bus.epc_cs_n = 1'b0; bus.epc_ads = 1'b1; bus.epc_rnw = v.rnw;
      bus.epc_addr = v.addr; bus.epc_wdata = v.wdata; bus.epc_be = v.be;
      reg_ack = 1'b0; reg_rdata = 32'h0bad_0bad;
      @(posedge clk); #1;
      bus.epc_ads = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         if (v.abort_at != 0 && c >= v.abort_at) bus.epc_cs_n = 1'b1;
         else if (rdy_cyc != 0 && c > rdy_cyc + v.hold) bus.epc_cs_n = 1'b1;
         else if (c >= 15) bus.epc_cs_n = 1'b1;
         bus.epc_ads = (rdy_cyc != 0) && !bus.epc_cs_n;
         reg_ack   = (v.ack_dly >= 0) && (c == 1 + v.ack_dly);
         reg_rdata = reg_ack ? v.rd_in : 32'h0bad_0bad;
         @(negedge clk);
         if ((reg_wr || reg_rd) && strobe_cyc == 0) strobe_cyc = c;
         wr_n += int'(reg_wr);
         rd_n += int'(reg_rd);
         if (bus.epc_rdy) begin
            rdy_n++;
            if (rdy_cyc == 0) begin
               rdy_cyc   = c;
               rd_at_rdy = bus.epc_rdata;
            end
         end else if (bus.epc_rdata !== 32'd0) begin
            leak_n++;
         end
         @(posedge clk); #1;
      end
      bus.epc_ads = 1'b0;
      reg_ack = 1'b0;
      chk({tag, "_strobe_cyc"}, strobe_cyc, v.exp_strobe);
      chk({tag, "_wr_cnt"}, wr_n, (v.exp_strobe != 0 && !v.rnw) ? 1 : 0);
      chk({tag, "_rd_cnt"}, rd_n, (v.exp_strobe != 0 && v.rnw) ? 1 : 0);
      chk({tag, "_rdy_cyc"}, rdy_cyc, v.exp_rdy);
      chk({tag, "_rdy_cnt"}, rdy_n, (v.exp_rdy != 0) ? 1 : 0);
      chk({tag, "_rdata"}, rd_at_rdy, v.exp_rdata);
      chk({tag, "_rdata_idle"}, leak_n, 0);
      chk({tag, "_err_cnt"}, {24'd0, err_cnt}, {24'd0, v.exp_err});
      chk({tag, "_reg_addr"}, {19'd0, reg_addr}, {19'd0, v.addr[12:0]});
      chk({tag, "_reg_wdata"}, reg_wdata, v.wdata);
      chk({tag, "_reg_be"}, {28'd0, reg_be}, {28'd0, v.be});
   endtask

   vec_t tbl[12];

   initial begin
      tbl[0]  = mk(0, 32'h0000_0100, 32'h1234_5678, 4'hf, 0, 32'h0, 0, 0, 1, 2, 32'h0, 8'd0);
      tbl[1]  = mk(1, 32'h0000_0314, 32'h0, 4'hf, 3, 32'h0000_004f, 0, 0, 1, 5, 32'h4f, 8'd0);
      tbl[2]  = mk(0, 32'haaaa_aaaa, 32'h5555_5555, 4'hf, -1, 32'h0, 0, 0, 0, 2, 32'h0, 8'd1);
      tbl[3]  = mk(1, 32'ha5a5_a5a5, 32'h0, 4'hf, -1, 32'h0, 0, 0, 0, 2, 32'h0, 8'd2);
      tbl[4]  = mk(1, 32'h0000_1004, 32'h0, 4'hf, -1, 32'h0, 3, 0, 1, 10, 32'hdead_beef, 8'd3);
      tbl[5]  = mk(1, 32'h0000_1ffc, 32'h0, 4'hf, 1, 32'hcafe_f00d, 0, 0, 1, 3, 32'hcafe_f00d,
                   8'd3);
      tbl[6]  = mk(0, 32'h0000_2000, 32'h1111_1111, 4'h3, -1, 32'h0, 0, 0, 0, 2, 32'h0, 8'd4);
      tbl[7]  = mk(1, 32'h0000_0008, 32'h0, 4'hf, 8, 32'h600d_cafe, 0, 0, 1, 10, 32'h600d_cafe,
                   8'd4);
      tbl[8]  = mk(1, 32'h0000_000c, 32'h0, 4'hf, 9, 32'h1212_1212, 0, 0, 1, 10, 32'hdead_beef,
                   8'd5);
      tbl[9]  = mk(0, 32'h0000_0004, 32'ha1b2_c3d4, 4'h8, 2, 32'hffff_ffff, 0, 0, 1, 4, 32'h0,
                   8'd5);
      tbl[10] = mk(1, 32'h0000_0200, 32'h0, 4'hf, -1, 32'h0, 0, 3, 1, 0, 32'h0, 8'd5);
      tbl[11] = mk(1, 32'h0000_0010, 32'h0, 4'hf, 0, 32'h0000_abcd, 0, 0, 1, 2, 32'habcd, 8'd5);

      bus.epc_cs_n = 1'b1; bus.epc_ads = 1'b0; bus.epc_rnw = 1'b0;
      bus.epc_addr = '0; bus.epc_wdata = '0; bus.epc_be = '0;
      reg_ack = 1'b0; reg_rdata = '0;
      rst = 1'b1;
      #1;
      chk("reset_rdy", {31'd0, bus.epc_rdy}, 32'd0);
      chk("reset_rdata", bus.epc_rdata, 32'd0);
      chk("reset_strobes", {30'd0, reg_wr, reg_rd}, 32'd0);
      chk("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) run_and_check($sformatf("v%0d", i), tbl[i]);

      // Reset while waiting for an ack that never comes.
      bus.epc_cs_n = 1'b0; bus.epc_ads = 1'b1; bus.epc_rnw = 1'b1;
      bus.epc_addr = 32'h0000_1004; bus.epc_wdata = 32'h7777_7777; bus.epc_be = 4'h6;
      @(posedge clk); #1;
      bus.epc_ads = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_wait_rdy", {31'd0, bus.epc_rdy}, 32'd0);
      chk("rst_wait_rdata", bus.epc_rdata, 32'd0);
      chk("rst_wait_strobes", {30'd0, reg_wr, reg_rd}, 32'd0);
      chk("rst_wait_reg_addr", {19'd0, reg_addr}, 32'd0);
      chk("rst_wait_reg_wdata", reg_wdata, 32'd0);
      chk("rst_wait_reg_be", {28'd0, reg_be}, 32'd0);
      chk("rst_wait_err_cnt", {24'd0, err_cnt}, 32'd0);
      bus.epc_cs_n = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      run_and_check("post_rst", mk(1, 32'h0000_0100, 32'h0, 4'hf, 0, 32'h1357_9bdf, 0, 0, 1, 2,
                                   32'h1357_9bdf, 8'd0));

      // Out-of-range reads until the error counter saturates.
      for (int i = 0; i < 260; i++) begin
         run_and_check($sformatf("sat%0d", i),
                       mk(1, 32'h0001_0000 + 32'(i * 4), 32'h0, 4'hf, -1, 32'h0, 0, 0, 0, 2,
                          32'h0, (i + 1 > 255) ? 8'd255 : 8'(i + 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
